// File: rtl/mac_reg_bridge.sv
// Bridges the mac_reset sequencer and a host Avalon-MM master onto the MAC register slave.
// One MAC access in flight at a time, every access bounded by a waitrequest timeout.
module mac_reg_bridge #(
   parameter int unsigned IDLE_GAP       = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rst_finish,
   input  logic [7:0]  rst_addr,
   input  logic [31:0] rst_writedata,
   input  logic        rst_rd,
   input  logic        rst_wr,
   output logic        reg_busy,
   output logic [31:0] rst_readdata,
   input  logic [7:0]  host_address,
   input  logic        host_read,
   input  logic        host_write,
   input  logic [31:0] host_writedata,
   output logic [31:0] host_readdata,
   output logic        host_waitrequest,
   output logic [7:0]  mac_address,
   output logic        mac_read,
   output logic        mac_write,
   output logic [31:0] mac_writedata,
   input  logic [31:0] mac_readdata,
   input  logic        mac_waitrequest,
   output logic        timeout_err
);

   localparam int unsigned GapW  = (IDLE_GAP > 2) ? $clog2(IDLE_GAP) : 1;
   localparam int unsigned TimeW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [GapW-1:0]  GapLast  = GapW'(IDLE_GAP - 1);
   localparam logic [TimeW-1:0] TimeLast = TimeW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StSeqXfer, StHostXfer, StHostAck, StGap} state_e;

   state_e           state_q, state_d;
   logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
   logic [TimeW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             reg_busy_q, reg_busy_d;
   logic [31:0]      rst_readdata_q, rst_readdata_d;
   logic [31:0]      host_readdata_q, host_readdata_d;
   logic             host_wait_q, host_wait_d;
   logic [7:0]       mac_address_q, mac_address_d;
   logic             mac_read_q, mac_read_d;
   logic             mac_write_q, mac_write_d;
   logic [31:0]      mac_writedata_q, mac_writedata_d;
   logic             timeout_err_q, timeout_err_d;
   logic             timed_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= StGap;
         gap_cnt_q       <= '0;
         tmo_cnt_q       <= '0;
         reg_busy_q      <= 1'b0;
         rst_readdata_q  <= '0;
         host_readdata_q <= '0;
         host_wait_q     <= 1'b1;
         mac_address_q   <= '0;
         mac_read_q      <= 1'b0;
         mac_write_q     <= 1'b0;
         mac_writedata_q <= '0;
         timeout_err_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         gap_cnt_q       <= gap_cnt_d;
         tmo_cnt_q       <= tmo_cnt_d;
         reg_busy_q      <= reg_busy_d;
         rst_readdata_q  <= rst_readdata_d;
         host_readdata_q <= host_readdata_d;
         host_wait_q     <= host_wait_d;
         mac_address_q   <= mac_address_d;
         mac_read_q      <= mac_read_d;
         mac_write_q     <= mac_write_d;
         mac_writedata_q <= mac_writedata_d;
         timeout_err_q   <= timeout_err_d;
      end
   end

   // Timeout fires after exactly TIMEOUT_CYCLES strobe cycles with waitrequest high.
   assign timed_out = mac_waitrequest && (tmo_cnt_q == TimeLast);

   always_comb begin
      state_d         = state_q;
      gap_cnt_d       = gap_cnt_q;
      tmo_cnt_d       = tmo_cnt_q;
      reg_busy_d      = reg_busy_q;
      rst_readdata_d  = rst_readdata_q;
      host_readdata_d = host_readdata_q;
      host_wait_d     = host_wait_q;
      mac_address_d   = mac_address_q;
      mac_read_d      = mac_read_q;
      mac_write_d     = mac_write_q;
      mac_writedata_d = mac_writedata_q;
      timeout_err_d   = timeout_err_q;

      unique case (state_q)
         StIdle: begin
            if (!rst_finish && (rst_wr || rst_rd)) begin
               mac_address_d   = rst_addr;
               mac_writedata_d = rst_writedata;
               mac_write_d     = rst_wr;
               mac_read_d      = !rst_wr;
               reg_busy_d      = 1'b1;
               tmo_cnt_d       = '0;
               state_d         = StSeqXfer;
            end else if (rst_finish && (host_write || host_read)) begin
               mac_address_d   = host_address;
               mac_writedata_d = host_writedata;
               mac_write_d     = host_write;
               mac_read_d      = !host_write;
               tmo_cnt_d       = '0;
               state_d         = StHostXfer;
            end
         end
         StSeqXfer, StHostXfer: begin
            if (!mac_waitrequest || timed_out) begin
               mac_read_d  = 1'b0;
               mac_write_d = 1'b0;
               if (timed_out) begin
                  timeout_err_d = 1'b1;
               end
               if (state_q == StSeqXfer) begin
                  if (mac_read_q) begin
                     rst_readdata_d = timed_out ? '0 : mac_readdata;
                  end
                  reg_busy_d = 1'b0;
                  gap_cnt_d  = '0;
                  state_d    = StGap;
               end else begin
                  if (mac_read_q) begin
                     host_readdata_d = timed_out ? '0 : mac_readdata;
                  end
                  host_wait_d = 1'b0;
                  state_d     = StHostAck;
               end
            end else begin
               tmo_cnt_d = tmo_cnt_q + TimeW'(1);
            end
         end
         StHostAck: begin
            host_wait_d = 1'b1;
            gap_cnt_d   = '0;
            state_d     = StGap;
         end
         StGap: begin
            if (gap_cnt_q == GapLast) begin
               state_d = StIdle;
            end else begin
               gap_cnt_d = gap_cnt_q + GapW'(1);
            end
         end
         default: begin
            state_d = StGap;
         end
      endcase
   end

   assign reg_busy         = reg_busy_q;
   assign rst_readdata     = rst_readdata_q;
   assign host_readdata    = host_readdata_q;
   assign host_waitrequest = host_wait_q;
   assign mac_address      = mac_address_q;
   assign mac_read         = mac_read_q;
   assign mac_write        = mac_write_q;
   assign mac_writedata    = mac_writedata_q;
   assign timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_mac_reg_bridge.sv
// Bench for mac_reg_bridge: vector table for sequencer accesses, MAC slave model with a
// transaction scoreboard, plus hand sequences for host stall, timeout and mid-transfer reset.
module tb_mac_reg_bridge;

   localparam int unsigned IdleGap = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rst_finish = 1'b0;
   logic [7:0]  rst_addr = 8'h5A;
   logic [31:0] rst_writedata = 32'h1234_ABCD;
   logic        rst_rd = 1'b0;
   logic        rst_wr = 1'b0;
   logic        reg_busy;
   logic [31:0] rst_readdata;
   logic [7:0]  host_address = 8'h00;
   logic        host_read = 1'b0;
   logic        host_write = 1'b0;
   logic [31:0] host_writedata = 32'h0;
   logic [31:0] host_readdata;
   logic        host_waitrequest;
   logic [7:0]  mac_address;
   logic        mac_read;
   logic        mac_write;
   logic [31:0] mac_writedata;
   logic [31:0] mac_readdata = 32'h0;
   logic        mac_waitrequest = 1'b1;
   logic        timeout_err;

   int checks = 0;
   int failures = 0;

   typedef struct {
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] data;
   } txn_t;
   txn_t sb[$];

   typedef struct {
      bit          wr;
      bit          rd;
      logic [7:0]  addr;
      logic [31:0] data;
      int          wait_c;
      logic [31:0] rdata;
      int          exp_busy;
      logic [31:0] exp_rdata;
   } vec_t;
   vec_t vecs[8];

   int wait_cfg = 0;
   int wcnt = 0;

   mac_reg_bridge #(
      .IDLE_GAP       (IdleGap),
      .TIMEOUT_CYCLES (1023)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .rst_finish       (rst_finish),
      .rst_addr         (rst_addr),
      .rst_writedata    (rst_writedata),
      .rst_rd           (rst_rd),
      .rst_wr           (rst_wr),
      .reg_busy         (reg_busy),
      .rst_readdata     (rst_readdata),
      .host_address     (host_address),
      .host_read        (host_read),
      .host_write       (host_write),
      .host_writedata   (host_writedata),
      .host_readdata    (host_readdata),
      .host_waitrequest (host_waitrequest),
      .mac_address      (mac_address),
      .mac_read         (mac_read),
      .mac_write        (mac_write),
      .mac_writedata    (mac_writedata),
      .mac_readdata     (mac_readdata),
      .mac_waitrequest  (mac_waitrequest),
      .timeout_err      (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // MAC slave model: waitrequest high for wait_cfg strobe cycles, then low for one.
   always @(negedge clk) begin
      txn_t exp;
      if (mac_read || mac_write) begin
         mac_waitrequest = (wcnt < wait_cfg);
         wcnt++;
         if (!mac_waitrequest) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected: got addr %h wr %b, expected no transaction",
                        mac_address, mac_write);
            end else begin
               exp = sb.pop_front();
               check1("sb_kind_write", mac_write, exp.wr);
               check1("sb_one_strobe", mac_read & mac_write, 1'b0);
               check32("sb_addr", {24'h0, mac_address}, {24'h0, exp.addr});
               if (exp.wr) check32("sb_wdata", mac_writedata, exp.data);
            end
         end
      end else begin
         wcnt = 0;
         mac_waitrequest = 1'b1;
      end
   end

   // Called at a negedge; returns at the negedge where reg_busy is seen low again.
   task automatic seq_xfer(input vec_t v, input bit push, output int busy_cyc,
                           output int low_cyc);
      int n;
      wait_cfg = v.wait_c;
      mac_readdata = v.rdata;
      if (push) sb.push_back('{v.wr, v.addr, v.data});
      rst_addr = v.addr;
      rst_writedata = v.data;
      rst_wr = v.wr;
      rst_rd = v.rd;
      n = 0;
      while (!reg_busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      low_cyc = n;
      rst_wr = 1'b0;
      rst_rd = 1'b0;
      busy_cyc = 0;
      if (!reg_busy) begin
         checks++;
         failures++;
         $display("FAIL seq_start: reg_busy got 0 expected 1 within 20 cycles");
      end else begin
         while (reg_busy && busy_cyc < 3000) begin
            busy_cyc++;
            @(negedge clk);
         end
      end
   endtask

   task automatic host_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                            input int w, input logic [31:0] rd, output logic [31:0] got);
      int n;
      wait_cfg = w;
      mac_readdata = rd;
      sb.push_back('{wr, a, d});
      host_address = a;
      host_writedata = d;
      host_write = wr;
      host_read = !wr;
      n = 0;
      while (host_waitrequest && n < 50) begin
         @(negedge clk);
         n++;
      end
      check1("host_ack_seen", host_waitrequest, 1'b0);
      got = host_readdata;
      @(posedge clk);
      #1;
      host_write = 1'b0;
      host_read = 1'b0;
      @(negedge clk);
      check1("host_ack_one_cycle", host_waitrequest, 1'b1);
   endtask

   initial begin
      int busy, low;
      logic [31:0] got;
      bit stall_ok;
      vec_t tv;

      vecs[0] = '{1'b1, 1'b0, 8'd3,   32'h0615_0910, 0, 32'h0,         1, 32'h0};
      vecs[1] = '{1'b0, 1'b1, 8'd2,   32'h0,         5, 32'h0000_2000, 6, 32'h0000_2000};
      vecs[2] = '{1'b1, 1'b0, 8'd4,   32'hDEAD_BEEF, 2, 32'hFFFF_0000, 3, 32'h0000_2000};
      vecs[3] = '{1'b0, 1'b1, 8'd9,   32'h0,         0, 32'hA5A5_5A5A, 1, 32'hA5A5_5A5A};
      vecs[4] = '{1'b0, 1'b1, 8'hFF,  32'h0,         1, 32'h0,         2, 32'h0};
      vecs[5] = '{1'b1, 1'b0, 8'h80,  32'hFFFF_FFFF, 0, 32'h1111_1111, 1, 32'h0};
      vecs[6] = '{1'b0, 1'b1, 8'd7,   32'h0,         3, 32'h1234_5678, 4, 32'h1234_5678};
      vecs[7] = '{1'b1, 1'b1, 8'd10,  32'h0000_0055, 0, 32'h9999_9999, 1, 32'h1234_5678};

      repeat (3) @(negedge clk);
      check1("rst_reg_busy", reg_busy, 1'b0);
      check32("rst_rst_readdata", rst_readdata, 32'h0);
      check32("rst_host_readdata", host_readdata, 32'h0);
      check1("rst_host_waitrequest", host_waitrequest, 1'b1);
      check1("rst_mac_read", mac_read, 1'b0);
      check1("rst_mac_write", mac_write, 1'b0);
      check32("rst_mac_address", {24'h0, mac_address}, 32'h0);
      check32("rst_mac_writedata", mac_writedata, 32'h0);
      check1("rst_timeout_err", timeout_err, 1'b0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Back-to-back sequencer accesses from the vector table
      for (int i = 0; i < 8; i++) begin
         seq_xfer(vecs[i], 1'b1, busy, low);
         check32($sformatf("vec%0d_busy_cycles", i), busy, vecs[i].exp_busy);
         check32($sformatf("vec%0d_rst_readdata", i), rst_readdata, vecs[i].exp_rdata);
         if (i > 0)
            check1($sformatf("vec%0d_gap_ok(low=%0d)", i, low),
                   (low >= IdleGap) && (low <= IdleGap + 1), 1'b1);
      end
      check1("no_timeout_yet", timeout_err, 1'b0);

      // Timeout: waitrequest never drops
      repeat (4) @(negedge clk);
      tv = '{1'b0, 1'b1, 8'd5, 32'h0, 5000, 32'hFFFF_FFFF, 1023, 32'h0};
      seq_xfer(tv, 1'b0, busy, low);
      check32("timeout_busy_cycles", busy, 1023);
      check1("timeout_strobe_dropped", mac_read, 1'b0);
      check32("timeout_rst_readdata", rst_readdata, 32'h0);
      check1("timeout_err_set", timeout_err, 1'b1);

      // Host stall while sequencer still owns the bus
      repeat (4) @(negedge clk);
      wait_cfg = 0;
      host_address = 8'h21;
      host_writedata = 32'hCAFE_F00D;
      host_write = 1'b1;
      stall_ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (host_waitrequest !== 1'b1 || mac_write !== 1'b0) stall_ok = 1'b0;
      end
      check1("host_stalled", stall_ok, 1'b1);
      rst_finish = 1'b1;
      host_xfer(1'b1, 8'h21, 32'hCAFE_F00D, 0, 32'h0, got);
      check32("host_write_keeps_readdata", got, 32'h0);
      repeat (3) @(negedge clk);
      host_xfer(1'b0, 8'h30, 32'h0, 2, 32'hBEEF_0001, got);
      check32("host_read_data", got, 32'hBEEF_0001);
      check32("host_read_seq_untouched", rst_readdata, 32'h0);
      check1("timeout_err_sticky", timeout_err, 1'b1);

      // Reset during a sequencer transfer
      rst_finish = 1'b0;
      repeat (4) @(negedge clk);
      wait_cfg = 5000;
      rst_addr = 8'h11;
      rst_rd = 1'b1;
      for (int n = 0; n < 20 && !reg_busy; n++) @(negedge clk);
      rst_rd = 1'b0;
      repeat (3) @(negedge clk);
      check1("midrst_in_flight", mac_read, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check1("midrst_mac_read", mac_read, 1'b0);
      check1("midrst_mac_write", mac_write, 1'b0);
      check1("midrst_reg_busy", reg_busy, 1'b0);
      check1("midrst_host_waitrequest", host_waitrequest, 1'b1);
      check1("midrst_timeout_err", timeout_err, 1'b0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      check32("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
